// File: rtl/majority_bist.sv
// Self-test sequencer for a 3-input majority voter: walks all eight input vectors,
// samples the voter output after a settle time and records mismatches.
`timescale 1ns/1ps

module majority_bist #(
  parameter int SETTLE = 2,
  parameter int PASSES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       m,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [2:0] fail_vec,
  output logic       fail_valid
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);
  localparam logic [4:0] LAST_PASS   = 5'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, FIN} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] vec;
  logic [3:0] settle_cnt;
  logic [4:0] pass_cnt;
  logic       expected;
  logic       mismatch;
  logic       last_vec;
  logic       last_pass;
  logic       check_en;

  assign expected  = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
  assign mismatch  = (m != expected);
  assign last_vec  = (vec == 3'b111);
  assign last_pass = (pass_cnt == LAST_PASS);
  assign {a, b, c} = vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (settle_cnt == 4'd1) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_vec && last_pass) begin
          state_nxt = FIN;
        end else begin
          state_nxt = WAIT;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    check_en = 1'b0;
    case (state)
      WAIT: begin
        busy = 1'b1;
      end
      CHECK: begin
        busy     = 1'b1;
        check_en = !abort;
      end
      FIN: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Stimulus vector, counters and result registers; an abort discards the pending check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= 3'b000;
      settle_cnt <= 4'd0;
      pass_cnt   <= 5'd0;
      err_cnt    <= 8'd0;
      fail_vec   <= 3'b000;
      fail_valid <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec        <= 3'b000;
            settle_cnt <= SETTLE_LOAD;
            pass_cnt   <= 5'd0;
            err_cnt    <= 8'd0;
            fail_vec   <= 3'b000;
            fail_valid <= 1'b0;
            pass       <= 1'b0;
          end
        end
        WAIT: begin
          if (abort) begin
            vec <= 3'b000;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        CHECK: begin
          if (abort) begin
            vec <= 3'b000;
          end else begin
            if (check_en && mismatch) begin
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
              if (!fail_valid) begin
                fail_vec   <= vec;
                fail_valid <= 1'b1;
              end
            end
            if (!last_vec) begin
              vec        <= vec + 3'd1;
              settle_cnt <= SETTLE_LOAD;
            end else if (!last_pass) begin
              vec        <= 3'b000;
              pass_cnt   <= pass_cnt + 5'd1;
              settle_cnt <= SETTLE_LOAD;
            end
          end
        end
        FIN: begin
          pass <= (err_cnt == 8'd0);
          vec  <= 3'b000;
        end
        default: begin
          vec <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: doc/majority_bist.md
# majority_bist

Built-in self-test sequencer for the 3-input majority voter (inputs A, B, C, output M). It drives the voter's inputs directly, walking all eight input vectors in the order 000 to 111. After a programmable settle time it samples the voter's M output and checks it against the golden majority function. It reports pass/fail, an error count and the first failing vector to the lab top level.

## Interface
- SETTLE, 2: cycles each vector is held before M is sampled; legal range 1-15.
- PASSES, 1: number of full 8-vector sweeps per run; legal range 1-16.

- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  begin a run; sampled only in IDLE.
- ABORT  in  1  synchronous; terminates a run in progress.
- M  in  1  majority output from the unit under test.
- A, B, C  out  1 each  registered stimulus to the unit under test; vector V = {A,B,C}, C is the LSB.
- BUSY  out  1  high from the cycle after START is accepted until the run ends.
- DONE  out  1  one-cycle pulse when a run completes normally.
- PASS  out  1  high after a completed run with zero errors; held until the next START or reset.
- ERR_CNT  out  8  mismatch count, saturating at 255.
- FAIL_VEC  out  3  first vector whose M mismatched.
- FAIL_VALID  out  1  FAIL_VEC holds a captured value.

## Operation
- States: IDLE, WAIT, CHECK, FIN.
- IDLE, START=1:
  - V <= 000, settle counter <= SETTLE, pass counter <= 0.
  - ERR_CNT, PASS, FAIL_VALID and FAIL_VEC are cleared.
  - Next state is WAIT; BUSY rises.
- WAIT: counter decrements each cycle. When it reaches 1, the next state is CHECK, so WAIT lasts exactly SETTLE cycles.
- CHECK (one cycle): M is sampled and compared with expected = A&B | A&C | B&C of the current V.
  - Mismatch: ERR_CNT increments, saturating at 255. If FAIL_VALID=0, FAIL_VEC <= V and FAIL_VALID <= 1.
  - If V != 111: V <= V+1, counter reloads SETTLE, next state is WAIT.
  - If V = 111 and pass counter < PASSES-1: pass counter increments, V wraps to 000, next state is WAIT.
  - If V = 111 on the last pass: next state is FIN. The ERR_CNT update from this final check is visible in FIN.
- FIN (one cycle):
  - DONE=1 and BUSY=0.
  - PASS <= (ERR_CNT == 0); the updated count from the final CHECK is used.
  - V <= 000; next state is IDLE.
- ABORT=1 in WAIT or CHECK:
  - Next state is IDLE, V <= 000, BUSY drops. DONE is not pulsed and PASS stays 0.
  - ERR_CNT, FAIL_VEC and FAIL_VALID keep their values.
  - Any check in that cycle is discarded.
- START while BUSY is ignored. ABORT in IDLE or FIN is ignored.
- If START and ABORT are both high in IDLE, START wins. ABORT is not examined until the next cycle.

## Timing
- Reset values: A=B=C=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=000, FAIL_VALID=0, state IDLE.
- RST_N low at any time, including mid-run, forces reset values immediately (asynchronously). The block resumes from IDLE after the first clock edge with RST_N high.
- START accepted at edge t:
  - BUSY=1 and V=000 from t+1.
  - Each vector is held for SETTLE+1 cycles.
- Total run length:
  - The DONE pulse occurs in cycle t+1+PASSES*8*(SETTLE+1).
  - BUSY is high for exactly PASSES*8*(SETTLE+1) cycles.
- The earliest next START is accepted in the cycle after DONE.
- M must be stable by the end of WAIT. The block samples it only in CHECK.
- ERR_CNT and FAIL_VEC update at the edge ending CHECK.

## Test plan
- Correct voter model, defaults, START pulse -> DONE in cycle t+25, PASS=1, ERR_CNT=0, FAIL_VALID=0. A,B,C sequence 000..111, each held 3 cycles.
- M stuck at 0 -> errors at 011, 101, 110, 111. ERR_CNT=4, FAIL_VEC=011, PASS=0.
- M = ~majority, PASSES=2 -> ERR_CNT=16, FAIL_VEC=000, DONE at t+49.
- PASSES=16, SETTLE=1, M stuck at 1 -> 16*4=64 errors, ERR_CNT=64, FAIL_VEC=000. Then force M inverted with PASSES=16 for 128 errors, then rerun without reset; ERR_CNT restarts from 0.
- ABORT during the vector-100 check -> BUSY low the next cycle, no DONE, PASS=0, A,B,C=000, ERR_CNT unchanged. A subsequent START runs fully.
- RST_N low mid-run and second START while BUSY:
  - RST_N low for 1 cycle mid-run -> all outputs at reset values immediately.
  - START pulsed again while BUSY -> no effect on sequence or DONE timing.
